// File: rtl/bram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_pkg
// Shared definitions for the BRAM read-side sequencer and its skid FIFO:
//   - default data/address widths, shared with the BRAM module
//   - read FIFO depth and the width of its occupancy count
//   - reader FSM state encodings
//   - can_issue(): decides whether another read may be launched
// Optional feature macro used by the reader: BRAM_READER_STRIDE_EN
// -----------------------------------------------------------------------------
package bram_stream_reader_pkg;

   localparam int DEFAULT_RAM_WIDTH  = 8;
   localparam int DEFAULT_NB_ADDRESS = 10;

   // Two slots: one word in flight from the BRAM plus one registered head.
   localparam int RD_FIFO_DEPTH = 2;
   localparam int RD_FIFO_CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   // A read may issue when the words already held or in flight, less the one
   // leaving this cycle, still leave a free FIFO slot. Written as
   // held < depth + pop so the arithmetic never underflows.
   function automatic logic can_issue(
      input logic [RD_FIFO_CNT_W-1:0] fifo_count,
      input logic                     inflight,
      input logic                     pop
   );
      logic [RD_FIFO_CNT_W:0] held;
      logic [RD_FIFO_CNT_W:0] limit;
      held  = {1'b0, fifo_count} + {{RD_FIFO_CNT_W{1'b0}}, inflight};
      limit = (RD_FIFO_CNT_W+1)'(RD_FIFO_DEPTH) + {{RD_FIFO_CNT_W{1'b0}}, pop};
      return (held < limit);
   endfunction

endpackage

// File: rtl/bram_stream_reader_rd_skid_fifo.sv
// -----------------------------------------------------------------------------
// rd_skid_fifo
// Two-entry synchronous FIFO that catches BRAM read data and holds the stream
// head stable under back-pressure.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_push, i_push_data   write one word (ignored when full and not popping)
//   i_pop                 remove the head word (ignored when empty)
//   o_count               number of words held (0..2)
//   o_head                oldest word; zero after reset
//   o_empty               no words held
// -----------------------------------------------------------------------------
module rd_skid_fifo
   import bram_stream_reader_pkg::*;
#(
   parameter int WIDTH = DEFAULT_RAM_WIDTH
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [RD_FIFO_CNT_W-1:0] o_count,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_empty
);

   logic [WIDTH-1:0]         mem_q [RD_FIFO_DEPTH];
   logic [WIDTH-1:0]         mem_d [RD_FIFO_DEPTH];
   logic                     rd_ptr_q, rd_ptr_d;
   logic                     wr_ptr_q, wr_ptr_d;
   logic [RD_FIFO_CNT_W-1:0] count_q, count_d;
   logic                     push_s, pop_s;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pop_s    = i_pop && (count_q != RD_FIFO_CNT_W'(0));
      // A push into a full FIFO is only legal when the head leaves together.
      push_s   = i_push && ((count_q != RD_FIFO_CNT_W'(RD_FIFO_DEPTH)) || pop_s);

      if (push_s) begin
         mem_d[wr_ptr_q] = i_push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + RD_FIFO_CNT_W'(1);
         2'b01:   count_d = count_q - RD_FIFO_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= RD_FIFO_CNT_W'(0);
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_count = count_q;
   assign o_head  = mem_q[rd_ptr_q];
   assign o_empty = (count_q == RD_FIFO_CNT_W'(0));

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Read-side sequencer for the line/pixel BRAM. Walks the BRAM read port from a
// base address for a given word count, absorbs the one-cycle read latency and
// presents the words as a valid/ready stream.
// Optional feature: define BRAM_READER_STRIDE_EN to add i_stride (latched on
// start) as the address increment; otherwise the increment is 1.
// Ports:
//   i_CLK, i_reset     clock, synchronous active-high reset
//   i_start            start request, honoured only in IDLE
//   i_baseAdd          first read address
//   i_length           number of words (0..2^NB_ADDRESS); 0 just pulses o_done
//   i_stride           address increment (BRAM_READER_STRIDE_EN only)
//   o_readAdd          BRAM read address, straight from the pointer register
//   i_data             BRAM registered read data
//   o_data, o_valid    stream output
//   i_ready            stream ready from the consumer
//   o_busy             not IDLE
//   o_done             one-cycle pulse after the last word leaves
// -----------------------------------------------------------------------------
module bram_stream_reader
   import bram_stream_reader_pkg::*;
#(
   parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
   parameter int NB_ADDRESS = DEFAULT_NB_ADDRESS,
   parameter int NB_COUNT   = NB_ADDRESS + 1
) (
   input  logic                  i_CLK,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [NB_ADDRESS-1:0] i_baseAdd,
   input  logic [NB_COUNT-1:0]   i_length,
`ifdef BRAM_READER_STRIDE_EN
   input  logic [NB_ADDRESS-1:0] i_stride,
`endif
   output logic [NB_ADDRESS-1:0] o_readAdd,
   input  logic [RAM_WIDTH-1:0]  i_data,
   output logic [RAM_WIDTH-1:0]  o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   rd_state_t                state_q, state_d;
   logic [NB_ADDRESS-1:0]    ptr_q, ptr_d;
   logic [NB_COUNT-1:0]      remain_q, remain_d;
   logic                     inflight_q, inflight_d;
   logic                     done_q, done_d;
`ifdef BRAM_READER_STRIDE_EN
   logic [NB_ADDRESS-1:0]    stride_q, stride_d;
`endif
   logic [NB_ADDRESS-1:0]    step_s;
   logic [RD_FIFO_CNT_W-1:0] fifo_count_s;
   logic                     fifo_empty_s;
   logic                     pop_s;
   logic                     issue_s;

`ifdef BRAM_READER_STRIDE_EN
   assign step_s = stride_q;
`else
   assign step_s = NB_ADDRESS'(1);
`endif

   assign pop_s   = ~fifo_empty_s & i_ready;
   assign issue_s = (state_q == ST_RUN) && (remain_q != NB_COUNT'(0))
                    && can_issue(fifo_count_s, inflight_q, pop_s);

   // Sequencer next-state: start handling, read issue and completion.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      remain_d   = remain_q;
      inflight_d = 1'b0;
      done_d     = 1'b0;
`ifdef BRAM_READER_STRIDE_EN
      stride_d   = stride_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (i_length == NB_COUNT'(0)) begin
                  // Empty transfer: report completion without touching memory.
                  done_d = 1'b1;
               end else begin
                  state_d  = ST_RUN;
                  ptr_d    = i_baseAdd;
                  remain_d = i_length;
`ifdef BRAM_READER_STRIDE_EN
                  stride_d = i_stride;
`endif
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (issue_s) begin
               // Pointer wraps silently modulo the BRAM size.
               ptr_d      = ptr_q + step_s;
               remain_d   = remain_q - NB_COUNT'(1);
               inflight_d = 1'b1;
               if (remain_q == NB_COUNT'(1)) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (remain_q == NB_COUNT'(0)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Finished once nothing is in flight and the last held word leaves.
            if (!inflight_q && (fifo_empty_s ||
                ((fifo_count_s == RD_FIFO_CNT_W'(1)) && pop_s))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge i_CLK) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= NB_ADDRESS'(0);
         remain_q   <= NB_COUNT'(0);
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef BRAM_READER_STRIDE_EN
         stride_q   <= NB_ADDRESS'(0);
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         remain_q   <= remain_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
`ifdef BRAM_READER_STRIDE_EN
         stride_q   <= stride_d;
`endif
      end
   end

   // The word read last cycle is on i_data now; capture it while inflight.
   rd_skid_fifo #(
      .WIDTH (RAM_WIDTH)
   ) u_fifo (
      .i_clk       (i_CLK),
      .i_reset     (i_reset),
      .i_push      (inflight_q),
      .i_push_data (i_data),
      .i_pop       (pop_s),
      .o_count     (fifo_count_s),
      .o_head      (o_data),
      .o_empty     (fifo_empty_s)
   );

   assign o_readAdd = ptr_q;
   assign o_valid   = ~fifo_empty_s;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Self-checking bench for bram_stream_reader with a behavioural BRAM (one-cycle
// registered read). Expected words come from a queue built from the bench's
// memory image using base + i*stride modulo 1024.
// Honours BRAM_READER_STRIDE_EN (drives i_stride and runs stride cases).
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  base_in;
   logic [10:0] len_in;
`ifdef BRAM_READER_STRIDE_EN
   logic [9:0]  stride_in;
`endif
   logic [9:0]  rd_add;
   logic [7:0]  ram_q;
   logic [7:0]  dout;
   logic        valid;
   logic        ready;
   logic        busy;
   logic        done;

   logic [7:0]  mem [1024];

   int          checks;
   int          errors;

   typedef struct {
      logic [9:0]  base;
      logic [10:0] len;
      int          rmode;     // 0 ready high, 1 fixed toggle pattern, 2 random
      logic        ghost;     // pulse a second start while running
      int          exp_done;  // cycle of o_done, -1 when timing is not fixed
      logic [7:0]  exp_first;
      logic [7:0]  exp_last;
   } vec_t;

   vec_t        vt [8];
   int          dc, fc;
   logic [7:0]  fw, lw;
   logic [9:0]  rb;
   logic [10:0] rl;
   logic [9:0]  rs;
   logic        any_done, any_valid;

   bram_stream_reader #(
      .RAM_WIDTH  (8),
      .NB_ADDRESS (10),
      .NB_COUNT   (11)
   ) dut (
      .i_CLK     (clk),
      .i_reset   (rst),
      .i_start   (start),
      .i_baseAdd (base_in),
      .i_length  (len_in),
`ifdef BRAM_READER_STRIDE_EN
      .i_stride  (stride_in),
`endif
      .o_readAdd (rd_add),
      .i_data    (ram_q),
      .o_data    (dout),
      .o_valid   (valid),
      .i_ready   (ready),
      .o_busy    (busy),
      .o_done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural BRAM read port: address sampled at the edge, data next cycle.
   always @(posedge clk) ram_q <= mem[rd_add];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_addr();
      for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
   endtask

   // One transfer; called right after a falling edge, that cycle is cycle 0.
   task automatic run_xfer(input logic [9:0] base, input logic [10:0] len,
                           input logic [9:0] stride, input int rmode, input logic ghost,
                           output int done_cyc, output int first_cyc,
                           output logic [7:0] first_w, output logic [7:0] last_w);
      logic [7:0] exp_q [$];
      logic [5:0] pat;
      logic [7:0] stall_d;
      logic       stall_p;
      logic       r;
      int         cyc, limit, ndone;
      pat = 6'b101001;
      for (int i = 0; i < int'(len); i++)
         exp_q.push_back(mem[(int'(base) + i * int'(stride)) % 1024]);
      done_cyc = -1; first_cyc = -1; first_w = 8'd0; last_w = 8'd0;
      ndone = 0; stall_p = 1'b0; stall_d = 8'd0;
      limit = 20 * int'(len) + 40;
      base_in = base; len_in = len; start = 1'b1; ready = 1'b1;
`ifdef BRAM_READER_STRIDE_EN
      stride_in = stride;
`endif
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc <= limit && ndone == 0) begin
         if (cyc == 1 && len != 11'd0) chk("first_addr", rd_add, base);
         if (stall_p) begin
            chk("stall_valid", valid, 32'd1);
            chk("stall_data", dout, stall_d);
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            chk("done_busy", busy, 32'd0);
            chk("done_valid", valid, 32'd0);
         end
         if (cyc == 2 && ghost) begin
            start = 1'b1; base_in = base + 10'd300; len_in = 11'd5;
         end else begin
            start = 1'b0; base_in = base; len_in = len;
         end
         case (rmode)
            0:       r = 1'b1;
            1:       r = pat[(cyc - 1) % 6];
            default: r = 1'($urandom_range(0, 1));
         endcase
         ready = r;
         if (valid && r) begin
            if (first_cyc < 0) begin
               first_cyc = cyc;
               first_w   = dout;
            end
            last_w = dout;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_word: got %0h expected no word", dout);
            end else begin
               chk("word", dout, exp_q.pop_front());
            end
         end
         stall_p = valid && !r;
         stall_d = dout;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (ndone == 0) begin
         checks++; errors++;
         $display("FAIL timeout: no done after %0d cycles, expected done", limit);
      end else begin
         chk("done_pulse", done, 32'd0);
      end
      chk("words_left", exp_q.size(), 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b0; base_in = 10'd0; len_in = 11'd0; ready = 1'b0;
`ifdef BRAM_READER_STRIDE_EN
      stride_in = 10'd1;
`endif
      fill_addr();
      repeat (3) @(negedge clk);
      chk("rst_valid", valid, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_addr", rd_add, 32'd0);
      chk("rst_data", dout, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      vt[0] = '{10'd5,    11'd4,    0, 1'b0, 7,    8'd5,   8'd8};
      vt[1] = '{10'd1022, 11'd4,    0, 1'b0, 7,    8'hFE,  8'h01};
      vt[2] = '{10'd0,    11'd8,    1, 1'b0, -1,   8'd0,   8'd7};
      vt[3] = '{10'd100,  11'd0,    0, 1'b0, 1,    8'd0,   8'd0};
      vt[4] = '{10'd20,   11'd6,    0, 1'b1, 9,    8'd20,  8'd25};
      vt[5] = '{10'd0,    11'd1,    0, 1'b0, 4,    8'd0,   8'd0};
      vt[6] = '{10'd7,    11'd1024, 0, 1'b0, 1027, 8'd7,   8'd6};
      vt[7] = '{10'd500,  11'd10,   2, 1'b0, -1,   8'd244, 8'd253};

      for (int k = 0; k < 8; k++) begin
         run_xfer(vt[k].base, vt[k].len, 10'd1, vt[k].rmode, vt[k].ghost, dc, fc, fw, lw);
         if (vt[k].exp_done >= 0) chk("done_cycle", dc, vt[k].exp_done);
         if (vt[k].len != 11'd0) begin
            chk("first_word", fw, vt[k].exp_first);
            chk("last_word", lw, vt[k].exp_last);
            if (vt[k].rmode == 0) chk("first_valid_cycle", fc, 32'd3);
         end else begin
            chk("zero_len_no_valid", fc, 32'hFFFF_FFFF);
         end
      end

      // Reset in the middle of a transfer after two words have left.
      start = 1'b1; base_in = 10'd0; len_in = 11'd8; ready = 1'b1;
      @(negedge clk); start = 1'b0;         // cycle 1
      @(negedge clk);                       // cycle 2
      @(negedge clk);                       // cycle 3
      chk("mid_w0_valid", valid, 32'd1);
      chk("mid_w0", dout, 32'd0);
      @(negedge clk);                       // cycle 4
      chk("mid_w1", dout, 32'd1);
      @(negedge clk);                       // cycle 5
      rst = 1'b1;
      @(negedge clk);                       // cycle 6
      chk("mid_rst_valid", valid, 32'd0);
      chk("mid_rst_busy", busy, 32'd0);
      chk("mid_rst_done", done, 32'd0);
      chk("mid_rst_addr", rd_add, 32'd0);
      rst = 1'b0;
      any_done = 1'b0; any_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any_done  = any_done | done;
         any_valid = any_valid | valid;
      end
      chk("mid_rst_no_done", any_done, 32'd0);
      chk("mid_rst_no_valid", any_valid, 32'd0);
      run_xfer(10'd10, 11'd2, 10'd1, 0, 1'b0, dc, fc, fw, lw);
      chk("post_rst_first", fw, 32'd10);
      chk("post_rst_last", lw, 32'd11);
      chk("post_rst_done", dc, 32'd5);

`ifdef BRAM_READER_STRIDE_EN
      run_xfer(10'd0, 11'd3, 10'd32, 0, 1'b0, dc, fc, fw, lw);
      chk("stride_first", fw, 32'd0);
      chk("stride_last", lw, 32'd64);
      chk("stride_done", dc, 32'd6);
      run_xfer(10'd9, 11'd3, 10'd0, 1, 1'b0, dc, fc, fw, lw);
      chk("stride0_last", lw, 32'd9);
`endif

      // Random memory contents, addresses, lengths and back-pressure.
      for (int n = 0; n < 15; n++) begin
         for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
         rb = 10'($urandom_range(0, 1023));
         rl = 11'($urandom_range(1, 40));
         rs = 10'd1;
`ifdef BRAM_READER_STRIDE_EN
         rs = 10'($urandom_range(0, 1023));
`endif
         run_xfer(rb, rl, rs, 2, 1'($urandom_range(0, 1)), dc, fc, fw, lw);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side sequencer for the line/pixel BRAM. Given a base address and a word count, it walks the BRAM read port, absorbs the memory's one-cycle registered read latency, and presents the words as a valid/ready stream to the convolution datapath. Back-pressure never loses or duplicates a word. The block pairs with the BRAM's write side: the loader fills memory, this block drains it.

## Interface
- `RAM_WIDTH`, 8, data word width; matches the BRAM.
- `NB_ADDRESS`, 10, address width; the BRAM holds 2^NB_ADDRESS words.
- `NB_COUNT`, `NB_ADDRESS+1`, width of the length field, allowing up to 2^NB_ADDRESS words.

Ports:
- `i_CLK` in 1: single clock for the block and the BRAM.
- `i_reset` in 1: synchronous, active-high reset.
- `i_start` in 1: start request; honoured only in IDLE.
- `i_baseAdd` in NB_ADDRESS: first read address; latched on an accepted start.
- `i_length` in NB_COUNT: number of words to read; latched on an accepted start.
- `i_stride` in NB_ADDRESS: address increment. Present only with `BRAM_READER_STRIDE_EN`.
- `o_readAdd` out NB_ADDRESS: connects to the BRAM `i_readAdd`.
- `i_data` in RAM_WIDTH: connects to the BRAM `o_data`.
- `o_data` out RAM_WIDTH: stream data.
- `o_valid` out 1: stream valid.
- `i_ready` in 1: stream ready from the consumer.
- `o_busy` out 1: high in any state other than IDLE.
- `o_done` out 1: one-cycle pulse when a transfer completes.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** on `i_start`. Latch the address pointer from `i_baseAdd` and the remaining count from `i_length`.
- **Zero length:** if `i_length`==0, stay in IDLE and pulse `o_done` the next cycle. No reads are issued.
- **Read issue (RUN):**
  - A read issues when remaining count > 0 and (fifo_count + inflight − pop) < 2, where pop = `o_valid` & `i_ready` in the same cycle.
  - On issue: the BRAM samples `o_readAdd` at the clock edge; the pointer advances; remaining count decrements; `inflight` is set for one cycle.
- **Capture:** when `inflight` is set, `i_data` is written into a 2-entry FIFO at the end of that cycle.
- **Stream output:** `o_data` is the FIFO head; `o_valid` = FIFO not empty.
- **RUN → DRAIN:** when the last read issues.
- **DRAIN → IDLE:** when `inflight`==0 and the FIFO empties (last pop). `o_done` pulses in the cycle after the last pop.
- **Address arithmetic:** pointer += 1, or += `i_stride` with the macro. Unsigned, modulo 2^NB_ADDRESS; the wrap is silent.
- **Start while not IDLE:** `i_start` is ignored; latched values do not change.
- **Reset:**
  - State → IDLE; FIFO emptied; `inflight` cleared; any in-flight word is discarded.
  - Output reset values: `o_valid`=0, `o_busy`=0, `o_done`=0, `o_readAdd`=0, `o_data`=0.
  - A reset mid-transfer takes effect in the next cycle with no `o_done` pulse.
- **Stream rules:**
  - `o_data` is held stable while `o_valid` is high and `i_ready` is low.
  - Words appear in issue order, and each word appears exactly once.

## Timing
- **Start latency:** `i_start` in cycle 0 → first read issued in cycle 1 → data on `i_data` in cycle 2 → `o_valid` high in cycle 3.
- **Throughput:** sustained one word per cycle while `i_ready` is held high.
- **Back-pressure:** `i_ready` low stalls issue within 2 words. The FIFO depth of 2 covers the 1-cycle read latency plus the one registered head entry.
- **Completion:** with `i_ready` constantly high, a transfer of N words pulses `o_done` in cycle N+3.
- **Output timing:** `o_readAdd` is driven from the pointer register; there is no combinational path from `i_ready` to `o_readAdd`.

## Configuration
- **`BRAM_READER_STRIDE_EN` defined:**
  - Adds the `i_stride` port; it is latched on start together with base and length.
  - Enables column walks (e.g. stride = image width) for vertical kernel passes.
  - A stride of 0 reads the same address `i_length` times.
- **`BRAM_READER_STRIDE_EN` undefined:** the port is absent and the increment is fixed at 1.

## Structure
- **Shared package/header:**
  - FSM state encodings: `ST_IDLE`, `ST_RUN`, `ST_DRAIN`.
  - Default `RAM_WIDTH` and `NB_ADDRESS`, shared with the BRAM module.
  - FIFO depth constant `RD_FIFO_DEPTH`=2.
- **Sub-module `rd_skid_fifo`:**
  - 2-entry synchronous FIFO with push, pop, count and head outputs.
  - The reader FSM, pointer and counter stay in the top module.

## Test plan
- **Basic run:** memory preloaded with addr→addr; base=5, len=4, `i_ready`=1 → `o_data` 5,6,7,8 on cycles 3–6; `o_done` in cycle 7; `o_busy` falls with it.
- **Wrap-around:** base=1022, len=4 → words from addresses 1022, 1023, 0, 1 in order.
- **Back-pressure:** base=0, len=8; `i_ready` toggles 1,0,0,1,0,1… → exactly 0–7 delivered once each, in order; `o_data` stable during stalls; at most 2 words held.
- **Edge starts:**
  - len=0 → `o_done` the cycle after start; no `o_valid`.
  - `i_start` during RUN → no effect on the sequence.
- **Reset mid-transfer:** assert `i_reset` after 2 words → next cycle `o_valid`=0, `o_busy`=0, no `o_done`. A new start of base=10, len=2 then yields 10, 11.
- **Stride (macro on):** base=0, stride=32, len=3 → addresses 0, 32, 64 on `o_readAdd`, with matching data.
